ym3438_pg: RTL and testbench



---
 rtl/ym3438_pg.sv | 102 ++++++++++
 tb/tb_ym3438_pg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ym3438_pg.sv
// YM3438 phase generator: per-slot phase increment from fnum/block/detune/multi,
// then a SLOTS-deep 20-bit phase accumulator loop. All storage is c1-capture / c2-present.
module ym3438_pg #(
  parameter int SLOTS   = 24,
  parameter int PHASE_W = 20,
  parameter int INC_W   = 17
) (
  input  logic               MCLK,
  input  logic               IC,
  input  logic               c1,
  input  logic               c2,
  input  logic [11:0]        fnum_lfo,
  input  logic [2:0]         block,
  input  logic               dt_sign,
  input  logic [4:0]         dt_val,
  input  logic [3:0]         multi,
  input  logic               pg_reset,
  output logic [9:0]         pg_out,
  output logic [PHASE_W-1:0] pg_inc_dbg
);

  // Stage A (combinational from the live inputs, captured on c1)
  logic [INC_W+1:0] fnum_shifted;
  logic [INC_W-1:0] basic;
  logic [INC_W-1:0] det_a;

  // fnum << block needs up to INC_W+2 bits before the >>2 drops the low two
  assign fnum_shifted = {{(INC_W+2-12){1'b0}}, fnum_lfo} << block;
  assign basic        = fnum_shifted[INC_W+1:2];
  assign det_a        = dt_sign ? basic - {{(INC_W-5){1'b0}}, dt_val}
                                : basic + {{(INC_W-5){1'b0}}, dt_val};

  // Stage A masters / slaves
  logic [INC_W-1:0] det_m, det_s;
  logic [3:0]       multi_m, multi_s;
  logic             rst_a_m, rst_a_s;

  // Stage B
  logic [PHASE_W-1:0] prod_b;
  logic [PHASE_W-1:0] inc_b;
  logic [PHASE_W-1:0] inc_m, inc_s;
  logic               rst_b_m, rst_b_s;

  assign prod_b = PHASE_W'(det_s) * PHASE_W'(multi_s);
  assign inc_b  = (multi_s == 4'd0) ? PHASE_W'(det_s >> 1) : prod_b;

  // Accumulator loop
  logic [PHASE_W-1:0] sr [SLOTS];
  logic [PHASE_W-1:0] acc_out;
  logic [PHASE_W-1:0] new_acc;
  logic [PHASE_W-1:0] new_m;
  logic [PHASE_W-1:0] inc_dbg_m;

  assign acc_out = sr[SLOTS-1];
  assign new_acc = rst_b_s ? '0 : acc_out + inc_s;

  // Master latches: capture on c1 only; a repeated c1 simply overwrites
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      det_m     <= '0;
      multi_m   <= '0;
      rst_a_m   <= 1'b0;
      inc_m     <= '0;
      rst_b_m   <= 1'b0;
      new_m     <= '0;
      inc_dbg_m <= '0;
    end else if (c1) begin
      det_m     <= det_a;
      multi_m   <= multi;
      rst_a_m   <= pg_reset;
      inc_m     <= inc_b;
      rst_b_m   <= rst_a_s;
      new_m     <= new_acc;
      inc_dbg_m <= inc_s;
    end
  end

  // Slave latches: present on c2, including one shift of the slot loop
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      det_s      <= '0;
      multi_s    <= '0;
      rst_a_s    <= 1'b0;
      inc_s      <= '0;
      rst_b_s    <= 1'b0;
      pg_out     <= '0;
      pg_inc_dbg <= '0;
      for (int i = 0; i < SLOTS; i++) sr[i] <= '0;
    end else if (c2) begin
      det_s      <= det_m;
      multi_s    <= multi_m;
      rst_a_s    <= rst_a_m;
      inc_s      <= inc_m;
      rst_b_s    <= rst_b_m;
      pg_out     <= new_m[PHASE_W-1:PHASE_W-10];
      pg_inc_dbg <= inc_dbg_m;
      sr[0]      <= new_m;
      for (int i = 1; i < SLOTS; i++) sr[i] <= sr[i-1];
    end
  end

endmodule

// File: tb/tb_ym3438_pg.sv
// Bench for ym3438_pg: per-slot phase model driven step by step, plus literal lap values.
module tb_ym3438_pg;

  logic        MCLK = 1'b0;
  logic        IC = 1'b0;
  logic        c1 = 1'b0;
  logic        c2 = 1'b0;
  logic [11:0] fnum_lfo = '0;
  logic [2:0]  block = '0;
  logic        dt_sign = 1'b0;
  logic [4:0]  dt_val = '0;
  logic [3:0]  multi = '0;
  logic        pg_reset = 1'b0;
  logic [9:0]  pg_out;
  logic [19:0] pg_inc_dbg;

  ym3438_pg dut (
    .MCLK(MCLK), .IC(IC), .c1(c1), .c2(c2),
    .fnum_lfo(fnum_lfo), .block(block), .dt_sign(dt_sign), .dt_val(dt_val),
    .multi(multi), .pg_reset(pg_reset),
    .pg_out(pg_out), .pg_inc_dbg(pg_inc_dbg)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int errors = 0;

  // Reference: phase of each loop position, and increments in flight (2-step latency)
  int          phase [24];
  logic [19:0] exp_q [$];
  bit          rst_q [$];
  int          acc_step;
  logic [9:0]  out_log [0:511];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] model_inc(input int f, input int b, input int ds,
                                            input int dv, input int m);
    int basic, det;
    basic = ((f << b) >> 2) & 'h1FFFF;
    det   = (ds != 0) ? basic - dv : basic + dv;
    det   = det & 'h1FFFF;
    if (m == 0) return 20'(det >> 1);
    return 20'((det * m) & 'hFFFFF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 24; i++) phase[i] = 0;
    exp_q = {20'd0, 20'd0};
    rst_q = {1'b0, 1'b0};
    acc_step = 0;
  endtask

  task automatic scramble_inputs();
    fnum_lfo = 12'($urandom);
    block    = 3'($urandom);
    dt_sign  = 1'($urandom);
    dt_val   = 5'($urandom);
    multi    = 4'($urandom);
    pg_reset = 1'($urandom);
  endtask

  // One slot step: optional stray c1, real c1, idle gap, c2, then compare
  task automatic do_step(input logic [11:0] f, input logic [2:0] b, input logic ds,
                         input logic [4:0] dv, input logic [3:0] m, input logic pr,
                         input bit stray);
    logic [19:0] e_inc;
    bit          e_rst;
    int          idx;
    int          nv;
    @(negedge MCLK);
    if (stray) begin
      scramble_inputs();
      c1 = 1'b1;
      @(negedge MCLK);
      c1 = 1'b0;
    end
    fnum_lfo = f; block = b; dt_sign = ds; dt_val = dv; multi = m; pg_reset = pr;
    c1 = 1'b1;
    @(negedge MCLK);
    c1 = 1'b0;
    scramble_inputs();
    repeat ($urandom_range(0, 2)) @(negedge MCLK);
    c2 = 1'b1;
    @(negedge MCLK);
    c2 = 1'b0;
    exp_q.push_back(model_inc(int'(f), int'(b), int'(ds), int'(dv), int'(m)));
    rst_q.push_back(pr);
    e_inc = exp_q.pop_front();
    e_rst = rst_q.pop_front();
    idx = acc_step % 24;
    nv = e_rst ? 0 : ((phase[idx] + int'(e_inc)) & 'hFFFFF);
    phase[idx] = nv;
    check("pg_out", 32'(pg_out), 32'(nv >> 10));
    check("pg_inc_dbg", 32'(pg_inc_dbg), 32'(e_inc));
    if (acc_step < 512) out_log[acc_step] = pg_out;
    acc_step++;
  endtask

  task automatic do_reset();
    @(negedge MCLK);
    IC = 1'b0;
    repeat (3) begin
      c1 = 1'b1; @(negedge MCLK); c1 = 1'b0;
      c2 = 1'b1; @(negedge MCLK); c2 = 1'b0;
    end
    check("reset_pg_out", 32'(pg_out), 32'd0);
    check("reset_inc", 32'(pg_inc_dbg), 32'd0);
    IC = 1'b1;
    repeat (3) @(negedge MCLK);
    check("release_pg_out", 32'(pg_out), 32'd0);
    check("release_inc", 32'(pg_inc_dbg), 32'd0);
    model_reset();
  endtask

  task automatic run_uniform(input logic [11:0] f, input logic [2:0] b, input logic ds,
                             input logic [4:0] dv, input logic [3:0] m, input int laps);
    for (int i = 0; i < laps * 24 + 2; i++) do_step(f, b, ds, dv, m, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // fnum 0x400, block 4, multi 1: inc 0x1000, 4/8/12 per lap
    run_uniform(12'h400, 3'd4, 1'b0, 5'd0, 4'd1, 3);
    check("lit_m1_inc", 32'(pg_inc_dbg), 32'h01000);
    check("lit_m1_lap1", 32'(out_log[2]), 32'd4);
    check("lit_m1_lap2", 32'(out_log[26]), 32'd8);
    check("lit_m1_lap3", 32'(out_log[50]), 32'd12);

    // multi 0 halves: inc 0x800
    do_reset();
    run_uniform(12'h400, 3'd4, 1'b0, 5'd0, 4'd0, 2);
    check("lit_m0_inc", 32'(pg_inc_dbg), 32'h00800);
    check("lit_m0_lap1", 32'(out_log[2]), 32'd2);
    check("lit_m0_lap2", 32'(out_log[26]), 32'd4);

    // Largest increment: basic 0x1FFE0 * 15 = 0x1DFE20 -> 0xDFE20 after truncation
    do_reset();
    run_uniform(12'hFFF, 3'd7, 1'b0, 5'd0, 4'd15, 2);
    check("lit_max_inc", 32'(pg_inc_dbg), 32'hDFE20);
    check("lit_max_lap1", 32'(out_log[2]), 32'h37F);
    check("lit_max_lap2", 32'(out_log[26]), 32'h2FF);

    // Negative detune wraps: 1 - 3 = 0x1FFFE
    do_reset();
    run_uniform(12'h004, 3'd0, 1'b1, 5'd3, 4'd1, 1);
    check("lit_det_inc", 32'(pg_inc_dbg), 32'h1FFFE);
    check("lit_det_lap1", 32'(out_log[2]), 32'h07F);

    // Key-on phase reset on slot 5 during lap 3
    do_reset();
    for (int i = 0; i < 4 * 24 + 2; i++)
      do_step(12'h400, 3'd4, 1'b0, 5'd0, 4'd1, (i == 2 * 24 + 5), 1'b0);
    check("lit_kon_slot5", 32'(out_log[2 * 24 + 5 + 2]), 32'd0);
    check("lit_kon_slot6", 32'(out_log[2 * 24 + 6 + 2]), 32'd12);
    check("lit_kon_slot4", 32'(out_log[2 * 24 + 4 + 2]), 32'd12);
    check("lit_kon_next5", 32'(out_log[3 * 24 + 5 + 2]), 32'd4);
    check("lit_kon_next4", 32'(out_log[3 * 24 + 4 + 2]), 32'd16);

    // Random traffic with stray c1 pulses and occasional key-on
    do_reset();
    for (int i = 0; i < 150; i++)
      do_step(12'($urandom), 3'($urandom), 1'($urandom), 5'($urandom), 4'($urandom),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));

    // IC asserted between c1 and c2 clears outputs at once
    @(negedge MCLK);
    scramble_inputs();
    c1 = 1'b1;
    @(negedge MCLK);
    c1 = 1'b0;
    IC = 1'b0;
    #1;
    check("mid_ic_pg_out", 32'(pg_out), 32'd0);
    check("mid_ic_inc", 32'(pg_inc_dbg), 32'd0);
    @(negedge MCLK);
    c2 = 1'b1;
    @(negedge MCLK);
    c2 = 1'b0;
    IC = 1'b1;
    model_reset();
    @(negedge MCLK);
    check("post_ic_pg_out", 32'(pg_out), 32'd0);
    for (int i = 0; i < 80; i++)
      do_step(12'($urandom), 3'($urandom), 1'($urandom), 5'($urandom), 4'($urandom),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
